// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a valid/ready handshake and a two-entry
// (main + skid) buffer. It also provides flush, bubble insertion and
// saturating stall/flush performance counters.
module if_id_skid_reg #(
  parameter int                 INSTR_W   = 32,
  parameter int                 PC_W      = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000,
  parameter int                 CNT_W     = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [PC_W-1:0]    i_PCplus4,
  input  logic [INSTR_W-1:0] i_instrIn,
  input  logic               i_stall,
  input  logic               i_IF_flush,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instrOut,
  output logic [PC_W-1:0]    o_PCplus4Out,
  output logic [CNT_W-1:0]   o_stall_cnt,
  output logic [CNT_W-1:0]   o_flush_cnt
);

  logic               r_main_valid;
  logic [INSTR_W-1:0] r_main_instr;
  logic [PC_W-1:0]    r_main_pc;
  logic               r_skid_valid;
  logic [INSTR_W-1:0] r_skid_instr;
  logic [PC_W-1:0]    r_skid_pc;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic [CNT_W-1:0]   r_flush_cnt;

  logic w_accept;
  logic w_consume;
  logic w_advance;
  logic w_capture;

  // A full skid is the only thing that blocks fetch, so a second beat
  // can never arrive while the skid is occupied.
  assign o_ready   = ~r_skid_valid & ~i_rst;
  assign w_accept  = i_valid & o_ready;
  assign w_consume = r_main_valid & ~i_stall;
  assign w_advance = ~r_main_valid | w_consume;
  assign w_capture = ~i_IF_flush & ~w_advance & w_accept;

  // NOTE: every sequential block uses non-blocking assignments so all
  // registers update from the same pre-edge values, with no order dependence.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_main_valid <= 1'b0;
      r_main_instr <= NOP_INSTR;
      r_main_pc    <= '0;
      r_skid_valid <= 1'b0;
    end else if (i_IF_flush) begin
      r_main_valid <= 1'b0;
      r_main_instr <= NOP_INSTR;
      r_main_pc    <= i_PCplus4;
      r_skid_valid <= 1'b0;
    end else if (w_advance) begin
      if (r_skid_valid) begin
        r_main_valid <= 1'b1;
        r_main_instr <= r_skid_instr;
        r_main_pc    <= r_skid_pc;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_main_valid <= 1'b1;
        r_main_instr <= i_instrIn;
        r_main_pc    <= i_PCplus4;
      end else begin
        r_main_valid <= 1'b0;
        r_main_instr <= NOP_INSTR;
      end
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
    end
  end

  // NOTE: the skid payload has no reset; it is only ever read while
  // r_skid_valid is set, and that flag is reset.
  always_ff @(posedge i_clk) begin
    if (w_capture) begin
      r_skid_instr <= i_instrIn;
      r_skid_pc    <= i_PCplus4;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (r_main_valid && i_stall && !i_IF_flush && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (i_IF_flush && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign o_valid      = r_main_valid;
  assign o_instrOut   = r_main_instr;
  assign o_PCplus4Out = r_main_pc;
  assign o_stall_cnt  = r_stall_cnt;
  assign o_flush_cnt  = r_flush_cnt;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Self-checking bench for if_id_skid_reg. It uses a directed vector table,
// hand-written saturation/reset sequences, and random traffic checked against a queue model.
module tb_if_id_skid_reg;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        i_clk = 1'b0;
  logic        i_rst, i_valid, i_stall, i_IF_flush;
  logic [31:0] i_PCplus4, i_instrIn;
  logic        o_ready, o_valid;
  logic [31:0] o_instrOut, o_PCplus4Out;
  logic [CNT_W-1:0] o_stall_cnt, o_flush_cnt;

  if_id_skid_reg #(.CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_PCplus4(i_PCplus4), .i_instrIn(i_instrIn), .i_stall(i_stall),
    .i_IF_flush(i_IF_flush), .o_valid(o_valid), .o_instrOut(o_instrOut),
    .o_PCplus4Out(o_PCplus4Out), .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic v, input logic st, input logic fl,
                       input logic [31:0] ins, input logic [31:0] pc);
    i_rst = rst; i_valid = v; i_stall = st; i_IF_flush = fl;
    i_instrIn = ins; i_PCplus4 = pc;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  typedef struct {
    logic        rst, valid, stall, flush;
    logic [31:0] instr, pc;
    logic        e_ready, e_valid;
    logic [31:0] e_instr, e_pc;
    int          e_scnt, e_fcnt;
  } vec_t;

  vec_t vt[19];

  // Reference model: the stage is a FIFO of at most two beats.
  typedef struct { logic [31:0] instr, pc; } beat_t;
  beat_t       m_q[$];
  logic [31:0] m_pc;
  int          m_scnt, m_fcnt;

  task automatic model_step(input logic rst, input logic v, input logic st, input logic fl,
                            input logic [31:0] ins, input logic [31:0] pc);
    bit    rdy = (m_q.size() < 2) && !rst;
    bit    mv  = (m_q.size() > 0);
    beat_t b;
    if (rst) begin
      m_q.delete(); m_pc = 0; m_scnt = 0; m_fcnt = 0;
    end else begin
      if (mv && st && !fl) m_scnt = (m_scnt < CNT_MAX) ? m_scnt + 1 : CNT_MAX;
      if (fl)              m_fcnt = (m_fcnt < CNT_MAX) ? m_fcnt + 1 : CNT_MAX;
      if (fl) begin
        m_q.delete(); m_pc = pc;
      end else begin
        if (mv && !st) void'(m_q.pop_front());
        if (v && rdy) begin b.instr = ins; b.pc = pc; m_q.push_back(b); end
      end
      if (m_q.size() > 0) m_pc = m_q[0].pc;
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    //        rst v  st fl instr         pc       rdy ov  o_instr       o_pc    sc fc
    vt[0]  = '{1, 0, 0, 0, 32'h0,        32'h0,    0, 0, 32'h0,        32'h0,  0, 0};
    vt[1]  = '{0, 1, 0, 0, 32'h8C010004, 32'h4,    1, 1, 32'h8C010004, 32'h4,  0, 0};
    vt[2]  = '{0, 1, 0, 0, 32'h20020005, 32'h8,    1, 1, 32'h20020005, 32'h8,  0, 0};
    vt[3]  = '{0, 1, 0, 0, 32'h00221820, 32'hC,    1, 1, 32'h00221820, 32'hC,  0, 0};
    vt[4]  = '{0, 0, 0, 0, 32'h0,        32'h0,    1, 0, 32'h0,        32'hC,  0, 0};
    vt[5]  = '{0, 0, 0, 0, 32'h0,        32'h0,    1, 0, 32'h0,        32'hC,  0, 0};
    vt[6]  = '{0, 1, 0, 0, 32'h8C010004, 32'h4,    1, 1, 32'h8C010004, 32'h4,  0, 0};
    vt[7]  = '{0, 1, 1, 0, 32'h20020005, 32'h8,    1, 1, 32'h8C010004, 32'h4,  1, 0};
    vt[8]  = '{0, 1, 1, 0, 32'h20020005, 32'h8,    0, 1, 32'h8C010004, 32'h4,  2, 0};
    vt[9]  = '{0, 1, 1, 0, 32'h20020005, 32'h8,    0, 1, 32'h8C010004, 32'h4,  3, 0};
    vt[10] = '{0, 1, 0, 0, 32'h20020005, 32'h8,    0, 1, 32'h20020005, 32'h8,  3, 0};
    vt[11] = '{0, 0, 0, 0, 32'h0,        32'h0,    1, 0, 32'h0,        32'h8,  3, 0};
    vt[12] = '{0, 1, 0, 0, 32'h11111111, 32'h10,   1, 1, 32'h11111111, 32'h10, 3, 0};
    vt[13] = '{0, 1, 1, 0, 32'h22222222, 32'h14,   1, 1, 32'h11111111, 32'h10, 4, 0};
    vt[14] = '{0, 1, 1, 1, 32'h33333333, 32'h40,   0, 0, 32'h0,        32'h40, 4, 1};
    vt[15] = '{0, 0, 0, 0, 32'h0,        32'h0,    1, 0, 32'h0,        32'h40, 4, 1};
    vt[16] = '{0, 1, 0, 0, 32'h44444444, 32'h44,   1, 1, 32'h44444444, 32'h44, 4, 1};
    vt[17] = '{0, 1, 1, 1, 32'h55555555, 32'h48,   1, 0, 32'h0,        32'h48, 4, 2};
    vt[18] = '{0, 0, 0, 0, 32'h0,        32'h0,    1, 0, 32'h0,        32'h48, 4, 2};

    tick();
    for (int i = 0; i < 19; i++) begin
      drive(vt[i].rst, vt[i].valid, vt[i].stall, vt[i].flush, vt[i].instr, vt[i].pc);
      #1;
      check($sformatf("vec%0d ready", i), 64'(o_ready), 64'(vt[i].e_ready));
      tick();
      check($sformatf("vec%0d valid", i), 64'(o_valid), 64'(vt[i].e_valid));
      check($sformatf("vec%0d instr", i), 64'(o_instrOut), 64'(vt[i].e_instr));
      check($sformatf("vec%0d pc", i), 64'(o_PCplus4Out), 64'(vt[i].e_pc));
      check($sformatf("vec%0d stall_cnt", i), 64'(o_stall_cnt), 64'(vt[i].e_scnt));
      check($sformatf("vec%0d flush_cnt", i), 64'(o_flush_cnt), 64'(vt[i].e_fcnt));
    end

    // Stall counter saturation: starts at 4, 20 stalled cycles with a live beat.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h66666666, 32'h4C);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 5) check("stall_cnt mid", 64'(o_stall_cnt), 64'd9);
    end
    check("stall_cnt saturated", 64'(o_stall_cnt), 64'(CNT_MAX));
    check("stalled instr stable", 64'(o_instrOut), 64'h66666666);
    check("stalled valid", 64'(o_valid), 64'd1);

    // Reset mid-stall, with flush and a valid beat present as well.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h77777777, 32'h50);
    #1;
    check("ready low in reset", 64'(o_ready), 64'd0);
    tick();
    check("rst valid", 64'(o_valid), 64'd0);
    check("rst instr", 64'(o_instrOut), 64'h0);
    check("rst pc", 64'(o_PCplus4Out), 64'h0);
    check("rst stall_cnt", 64'(o_stall_cnt), 64'd0);
    check("rst flush_cnt", 64'(o_flush_cnt), 64'd0);

    // Flush counter saturation.
    for (int c = 0; c < 20; c++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h88888888, 32'(32'h100 + 4 * c));
      tick();
    end
    check("flush_cnt saturated", 64'(o_flush_cnt), 64'(CNT_MAX));
    check("flush pc", 64'(o_PCplus4Out), 64'h14C);
    check("flush valid", 64'(o_valid), 64'd0);

    // Random traffic against the queue model.
    for (int n = 0; n < 3000; n++) begin
      logic        r, v, s, f;
      logic [31:0] ins, pc;
      r   = (n == 0) || ($urandom_range(63) == 0);
      v   = ($urandom_range(3) != 0);
      s   = ($urandom_range(2) == 0);
      f   = ($urandom_range(11) == 0);
      ins = $urandom;
      pc  = $urandom;
      drive(r, v, s, f, ins, pc);
      #1;
      check("rand ready", 64'(o_ready), 64'((m_q.size() < 2) && !r));
      model_step(r, v, s, f, ins, pc);
      tick();
      check("rand valid", 64'(o_valid), 64'(m_q.size() > 0));
      check("rand instr", 64'(o_instrOut), 64'((m_q.size() > 0) ? m_q[0].instr : 32'h0));
      check("rand pc", 64'(o_PCplus4Out), 64'(m_pc));
      check("rand stall_cnt", 64'(o_stall_cnt), 64'(m_scnt));
      check("rand flush_cnt", 64'(o_flush_cnt), 64'(m_fcnt));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_id_skid_reg.md
Name: if_id_skid_reg

Overview:
Parametrised IF/ID pipeline register with a valid/ready handshake, replacing the plain stall/flush latch between fetch and decode. A two-entry skid buffer (main and skid) lets fetch keep issuing for one cycle after decode stalls. No beat is lost and order is preserved. Adds bubble (NOP) insertion, a flush that kills all buffered beats, and saturating stall/flush counters for performance debug.

Parameters:
INSTR_W, 32, instruction width
PC_W, 32, PC+4 width
NOP_INSTR, 32'h0000_0000, value driven on o_instrOut when the stage holds no valid beat
CNT_W, 16, width of the performance counters

Ports:
i_clk  in  1  clock; all state updates on the rising edge
i_rst  in  1  synchronous reset, active-high
i_valid  in  1  fetch presents a beat
o_ready  out  1  stage can accept a beat; combinational = ~skid_valid & ~i_rst
i_PCplus4  in  PC_W  incoming PC+4
i_instrIn  in  INSTR_W  incoming instruction
i_stall  in  1  decode cannot consume this cycle (hazard unit)
i_IF_flush  in  1  branch/jump taken; kill all buffered and incoming beats
o_valid  out  1  o_instrOut/o_PCplus4Out hold a live beat
o_instrOut  out  INSTR_W  instruction to decode
o_PCplus4Out  out  PC_W  PC+4 to decode
o_stall_cnt  out  CNT_W  cycles with o_valid & i_stall, saturating
o_flush_cnt  out  CNT_W  cycles with i_IF_flush, saturating

Behaviour:
- Reset (i_rst=1 at edge): o_valid=0, o_instrOut=NOP_INSTR, o_PCplus4Out=0, skid empty, both counters=0. o_ready=0 while i_rst is high. Reset overrides flush and every other input.
- Definitions: accept = i_valid & o_ready; consume = o_valid & ~i_stall.
- Flush (i_IF_flush=1, no reset), next edge:
  - o_valid=0 and skid emptied.
  - o_instrOut=NOP_INSTR; o_PCplus4Out=i_PCplus4.
  - An accepted beat in the same cycle is dropped.
  - Flush beats stall and consume.
- Normal update when main is empty or consume=1:
  - If skid is valid: main loads the skid beat, skid empties.
  - Else if accept: main loads the input beat.
  - Else: o_valid=0, o_instrOut=NOP_INSTR, o_PCplus4Out holds.
- Normal update when main holds a beat and i_stall=1: main holds; if accept, skid captures the input.
- The skid can never overflow, because o_ready=0 whenever the skid is valid.
- Latency: 1 cycle input→output when empty. Throughput: 1 beat/cycle with no stall.
- Ordering: strict FIFO; the skid beat always precedes any later input.
- Outputs hold stable while o_valid & i_stall.
- Counters:
  - o_stall_cnt increments on each cycle with o_valid & i_stall & ~i_IF_flush.
  - o_flush_cnt increments on each cycle with i_IF_flush.
  - Both saturate at all-ones, never wrap, and clear only on reset.
- Reset asserted mid-operation discards main and skid at the next edge, regardless of stall or flush.

Test Plan:
- Reset then stream: i_rst 1 cycle; i_valid=1 with instr 0x8C010004/PC 0x4, 0x20020005/0x8, 0x00221820/0xC, i_stall=0 → same beats on the outputs one cycle later, o_valid=1 continuously, o_ready=1 throughout.
- Stall with skid: main holds 0x8C010004; i_stall=1 for 3 cycles while fetch offers 0x20020005 → skid captures it, o_ready=0 from the next cycle; outputs stay 0x8C010004 and o_stall_cnt=3. Release stall → 0x20020005 appears next cycle, o_ready returns to 1.
- Flush with full skid: main and skid valid, i_IF_flush=1 with i_PCplus4=0x40 → next cycle o_valid=0, o_instrOut=0x0, o_PCplus4Out=0x40, skid empty, o_flush_cnt=1; neither buffered beat ever appears.
- Flush plus stall plus accept in the same cycle → flush wins; incoming beat dropped; o_stall_cnt unchanged.
- Bubble: i_valid=0 for 2 cycles with no stall → o_valid=0, o_instrOut=NOP_INSTR, o_PCplus4Out holds its last value.
- Saturation and reset: CNT_W=4, hold i_stall with o_valid for 20 cycles → o_stall_cnt stops at 15. Assert i_rst mid-stall → all outputs at reset values next edge, counters=0.
